// File: rtl/hazard_forward_ctrl.sv
// Hazard and forwarding controller for the 5-stage MIPS pipeline.
// Keeps its own copy of the ID/EX, EX/MEM and MEM/WB destination and control fields.
// From these and the ID-stage fields it produces the EX and ID forwarding selects,
// the load-use and branch stalls, the taken-branch flush, and saturating event counters.
module hazard_forward_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       id_dst,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             id_branch,
  input  logic             id_taken,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             fwd_c,
  output logic             fwd_d,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_bubble,
  output logic             ifid_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // Shadow copies of the pipeline register fields.
  logic [4:0]       ex_rs_q, ex_rt_q, ex_dst_q;
  logic             ex_rw_q, ex_mr_q;
  logic [4:0]       mem_dst_q;
  logic             mem_rw_q, mem_mr_q;
  logic [4:0]       wb_dst_q;
  logic             wb_rw_q;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  logic haz;
  logic h1_load_use, h2_branch_alu, h3_branch_load;

  // EX operand select. EX/MEM wins over MEM/WB, and $0 is never forwarded.
  function automatic logic [1:0] ex_fwd_sel(input logic [4:0] src,
                                            input logic       m_rw,
                                            input logic [4:0] m_dst,
                                            input logic       w_rw,
                                            input logic [4:0] w_dst);
    if (m_rw && (m_dst != 5'd0) && (m_dst == src)) begin
      return 2'b10;
    end else if (w_rw && (w_dst != 5'd0) && (w_dst == src)) begin
      return 2'b01;
    end
    return 2'b00;
  endfunction

  // True when a non-zero destination matches either ID source register.
  function automatic logic id_src_hit(input logic [4:0] dst,
                                      input logic [4:0] rs,
                                      input logic [4:0] rt);
    return (dst != 5'd0) && ((dst == rs) || (dst == rt));
  endfunction

  // Forwarding selects and hazard detection, all combinational in the current cycle.
  always_comb begin
    fwd_a = ex_fwd_sel(ex_rs_q, mem_rw_q, mem_dst_q, wb_rw_q, wb_dst_q);
    fwd_b = ex_fwd_sel(ex_rt_q, mem_rw_q, mem_dst_q, wb_rw_q, wb_dst_q);

    // A load result is not ready in MEM, so only ALU results feed the branch compare.
    fwd_c = mem_rw_q && !mem_mr_q && (mem_dst_q != 5'd0) && (mem_dst_q == id_rs);
    fwd_d = mem_rw_q && !mem_mr_q && (mem_dst_q != 5'd0) && (mem_dst_q == id_rt);

    h1_load_use    = ex_mr_q && id_src_hit(ex_dst_q, id_rs, id_rt);
    h2_branch_alu  = id_branch && ex_rw_q && id_src_hit(ex_dst_q, id_rs, id_rt);
    h3_branch_load = id_branch && mem_mr_q && id_src_hit(mem_dst_q, id_rs, id_rt);
    haz            = h1_load_use || h2_branch_alu || h3_branch_load;

    // A stall takes priority: the branch outcome is not trusted while stalled.
    pc_write    = !haz;
    ifid_write  = !haz;
    idex_bubble = haz;
    ifid_flush  = !haz && id_branch && id_taken;
  end

  // Advance the shadows every cycle. A bubble enters as all-zero fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_rs_q   <= 5'd0;
      ex_rt_q   <= 5'd0;
      ex_dst_q  <= 5'd0;
      ex_rw_q   <= 1'b0;
      ex_mr_q   <= 1'b0;
      mem_dst_q <= 5'd0;
      mem_rw_q  <= 1'b0;
      mem_mr_q  <= 1'b0;
      wb_dst_q  <= 5'd0;
      wb_rw_q   <= 1'b0;
    end else begin
      if (idex_bubble) begin
        ex_rs_q  <= 5'd0;
        ex_rt_q  <= 5'd0;
        ex_dst_q <= 5'd0;
        ex_rw_q  <= 1'b0;
        ex_mr_q  <= 1'b0;
      end else begin
        ex_rs_q  <= id_rs;
        ex_rt_q  <= id_rt;
        ex_dst_q <= id_dst;
        ex_rw_q  <= id_regwrite;
        ex_mr_q  <= id_memread;
      end
      mem_dst_q <= ex_dst_q;
      mem_rw_q  <= ex_rw_q;
      mem_mr_q  <= ex_mr_q;
      wb_dst_q  <= mem_dst_q;
      wb_rw_q   <= mem_rw_q;
    end
  end

  // Saturating counters for stall (bubble) cycles and flushes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (haz && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (ifid_flush && (flush_cnt_q != {CNT_W{1'b1}})) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed bench for hazard_forward_ctrl: a table of per-cycle ID inputs with expected
// outputs, plus sequences for async reset mid-stall, fresh counters and saturation.
module tb_hazard_forward_ctrl;

  logic        clk;
  logic        rst_n;
  logic [4:0]  id_rs, id_rt, id_dst;
  logic        id_regwrite, id_memread, id_branch, id_taken;
  logic [1:0]  fwd_a, fwd_b;
  logic        fwd_c, fwd_d, pc_write, ifid_write, idex_bubble, ifid_flush;
  logic [15:0] stall_cnt, flush_cnt;
  logic [1:0]  s_fwd_a, s_fwd_b;
  logic        s_fwd_c, s_fwd_d, s_pc_write, s_ifid_write, s_idex_bubble, s_ifid_flush;
  logic [1:0]  s_stall_cnt, s_flush_cnt;

  int checks = 0;
  int errors = 0;

  hazard_forward_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_dst(id_dst),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_branch(id_branch),
    .id_taken(id_taken), .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_c(fwd_c), .fwd_d(fwd_d),
    .pc_write(pc_write), .ifid_write(ifid_write), .idex_bubble(idex_bubble),
    .ifid_flush(ifid_flush), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // Narrow-counter copy on the same inputs, used for the saturation check.
  hazard_forward_ctrl #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_dst(id_dst),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_branch(id_branch),
    .id_taken(id_taken), .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .fwd_c(s_fwd_c),
    .fwd_d(s_fwd_d), .pc_write(s_pc_write), .ifid_write(s_ifid_write),
    .idex_bubble(s_idex_bubble), .ifid_flush(s_ifid_flush), .stall_cnt(s_stall_cnt),
    .flush_cnt(s_flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rs, rt, dst;
    logic       rw, mr, br, tk;
    logic [1:0] fa, fb;
    logic       fc, fd, bub, fl;
    int         sc, flc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int rs, int rt, int dst, bit rw, bit mr, bit br, bit tk,
                              int fa, int fb, bit fc, bit fd, bit bub, bit fl,
                              int sc, int flc);
    vec_t v;
    v.rs = rs[4:0]; v.rt = rt[4:0]; v.dst = dst[4:0];
    v.rw = rw; v.mr = mr; v.br = br; v.tk = tk;
    v.fa = fa[1:0]; v.fb = fb[1:0]; v.fc = fc; v.fd = fd; v.bub = bub; v.fl = fl;
    v.sc = sc; v.flc = flc;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] dst,
                       input logic rw, input logic mr, input logic br, input logic tk);
    id_rs = rs; id_rt = rt; id_dst = dst;
    id_regwrite = rw; id_memread = mr; id_branch = br; id_taken = tk;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
  endtask

  initial begin
    rst_n = 1'b0;
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #12;
    rst_n = 1'b1;
    next_cycle();

    // Reset state with idle inputs
    @(negedge clk);
    check("rst fwd_a", 0, 32'(fwd_a), 32'd0);
    check("rst fwd_b", 0, 32'(fwd_b), 32'd0);
    check("rst pc_write", 0, 32'(pc_write), 32'd1);
    check("rst idex_bubble", 0, 32'(idex_bubble), 32'd0);
    check("rst stall_cnt", 0, 32'(stall_cnt), 32'd0);
    next_cycle();

    //            rs rt dst rw mr br tk  fa fb fc fd bub fl  sc flc
    // add $3,$1,$2 ; sub $4,$3,$5
    tbl.push_back(mk(1, 2, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(3, 5, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // add $3 ; nop ; or $6,$7,$3
    tbl.push_back(mk(1, 2, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(7, 3, 6, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // lw $2,0($1) ; add $4,$2,$2 (held once by load-use)
    tbl.push_back(mk(1, 2, 2, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(2, 2, 4, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(2, 2, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    // lw $2 ; beq $2,$0 taken: two stalls then flush
    tbl.push_back(mk(1, 2, 2, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(2, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0, 1, 0));
    tbl.push_back(mk(2, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0, 2, 0));
    tbl.push_back(mk(2, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 3, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 1));
    // add $0,$1,$2 ; sub $4,$0,$0: $0 never forwarded
    tbl.push_back(mk(1, 2, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 1));
    tbl.push_back(mk(0, 0, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 1));
    // add $5 ; beq $5,$6: ALU-branch stall, then compare forward and taken flush
    tbl.push_back(mk(1, 2, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 1));
    tbl.push_back(mk(5, 6, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 3, 1));
    tbl.push_back(mk(5, 6, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0, 1, 4, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 4, 2));
    // add $7 ; add $7 ; sub $8,$7,$7: EX/MEM beats MEM/WB
    tbl.push_back(mk(1, 2, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4, 2));
    tbl.push_back(mk(1, 2, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4, 2));
    tbl.push_back(mk(7, 7, 8, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 4, 2));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 2, 2, 0, 0, 0, 0, 4, 2));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4, 2));
    // id_taken without id_branch: no flush
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 4, 2));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rs, tbl[i].rt, tbl[i].dst, tbl[i].rw, tbl[i].mr, tbl[i].br, tbl[i].tk);
      @(negedge clk);
      check("fwd_a", i, 32'(fwd_a), 32'(tbl[i].fa));
      check("fwd_b", i, 32'(fwd_b), 32'(tbl[i].fb));
      check("fwd_c", i, 32'(fwd_c), 32'(tbl[i].fc));
      check("fwd_d", i, 32'(fwd_d), 32'(tbl[i].fd));
      check("pc_write", i, 32'(pc_write), 32'(!tbl[i].bub));
      check("ifid_write", i, 32'(ifid_write), 32'(!tbl[i].bub));
      check("idex_bubble", i, 32'(idex_bubble), 32'(tbl[i].bub));
      check("ifid_flush", i, 32'(ifid_flush), 32'(tbl[i].fl));
      check("stall_cnt", i, 32'(stall_cnt), 32'(tbl[i].sc));
      check("flush_cnt", i, 32'(flush_cnt), 32'(tbl[i].flc));
      next_cycle();
    end

    // Async reset in the middle of a load-use stall
    drive(5'd1, 5'd2, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    next_cycle();
    drive(5'd2, 5'd2, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("pre-rst idex_bubble", 100, 32'(idex_bubble), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst pc_write", 101, 32'(pc_write), 32'd1);
    check("async rst ifid_write", 101, 32'(ifid_write), 32'd1);
    check("async rst idex_bubble", 101, 32'(idex_bubble), 32'd0);
    check("async rst ifid_flush", 101, 32'(ifid_flush), 32'd0);
    check("async rst fwd_a", 101, 32'(fwd_a), 32'd0);
    check("async rst stall_cnt", 101, 32'(stall_cnt), 32'd0);
    check("async rst flush_cnt", 101, 32'(flush_cnt), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();

    // lw $2 ; beq $2,$0 taken from fresh counters: stall_cnt 2, flush_cnt 1
    pulse_reset();
    drive(5'd1, 5'd2, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    next_cycle();
    for (int k = 0; k < 3; k++) begin
      drive(5'd2, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
      next_cycle();
    end
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("lw-beq stall_cnt", 102, 32'(stall_cnt), 32'd2);
    check("lw-beq flush_cnt", 102, 32'(flush_cnt), 32'd1);
    next_cycle();

    // Repeated lw $2,0($2): stall on every other cycle, 5 stalls in 11 cycles
    pulse_reset();
    for (int k = 0; k < 11; k++) begin
      drive(5'd2, 5'd2, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0);
      if (k < 10) next_cycle();
    end
    @(negedge clk);
    check("sat wide stall_cnt", 103, 32'(stall_cnt), 32'd5);
    check("sat narrow stall_cnt", 103, 32'(s_stall_cnt), 32'd3);
    check("sat narrow flush_cnt", 103, 32'(s_flush_cnt), 32'd0);
    next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Guard against a stuck run
  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish before 200000");
    $fatal(1);
  end

endmodule
